// File: rtl/trig_burst_sched.sv
// trig_burst_sched: issues bursts of trigger requests to the single-shot generator at a clamped period.
// Build option TRIG_SCHED_EXT_SYNC_EN: GAP->PULSE additionally waits for a latched i_ext_sync rising edge.
module trig_burst_sched #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8,
  parameter int EN_HI = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_period,
  input  logic [NUM_W-1:0] i_count,
  input  logic [3:0]       i_width,
  input  logic             i_level,
`ifdef TRIG_SCHED_EXT_SYNC_EN
  input  logic             i_ext_sync,
`endif
  output logic             o_trig_en,
  output logic [3:0]       o_trig_width,
  output logic             o_trig_level,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [NUM_W-1:0] o_pulse_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] EN_LAST = CNT_W'(EN_HI - 1);

  state_t           state_q, state_d;
  logic [1:0]       start_hist_q, start_hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic [3:0]       width_q, width_d;
  logic             level_q, level_d;
  logic             aborted_q, aborted_d;

  logic             start_edge;
  logic             burst_end;
  logic             gap_last;
  logic             pulse_ok;
  logic [CNT_W-1:0] per_min;
  logic [CNT_W-1:0] per_eff;
  logic [CNT_W-1:0] per_last;
  logic [CNT_W-1:0] cnt_inc;

  assign start_edge = (start_hist_q == 2'b01);
  assign burst_end  = (num_q != '0) && (idx_q == num_q);
  assign per_last   = per_q - CNT_W'(1);
  assign gap_last   = (cnt_q == per_last);
  // Saturate so a long ext-sync wait can never wrap back below P-1.
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Keep the period long enough for the generator to return to idle between edges.
  assign per_min = CNT_W'(i_width) + CNT_W'(8);
  assign per_eff = (i_period > per_min) ? i_period : per_min;

`ifdef TRIG_SCHED_EXT_SYNC_EN
  logic [1:0] sync_hist_q, sync_hist_d;
  logic       sync_lat_q, sync_lat_d;
  logic       sync_edge;

  assign sync_edge = (sync_hist_q == 2'b01);
  assign pulse_ok  = (cnt_q >= per_last) && sync_lat_q;

  always_comb begin
    sync_hist_d = {sync_hist_q[0], i_ext_sync};
    sync_lat_d  = sync_lat_q;
    if (state_q == S_GAP && sync_edge) begin
      sync_lat_d = 1'b1;
    end
    if (state_d == S_PULSE && state_q != S_PULSE) begin
      sync_lat_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_hist_q <= 2'b00;
      sync_lat_q  <= 1'b0;
    end else begin
      sync_hist_q <= sync_hist_d;
      sync_lat_q  <= sync_lat_d;
    end
  end
`else
  assign pulse_ok = gap_last;
`endif

  always_comb begin
    state_d      = state_q;
    start_hist_d = {start_hist_q[0], i_start};
    cnt_d        = cnt_q;
    per_d        = per_q;
    num_d        = num_q;
    idx_d        = idx_q;
    width_d      = width_q;
    level_d      = level_q;
    aborted_d    = aborted_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge && !i_stop) begin
          state_d   = S_ARM;
          idx_d     = '0;
          aborted_d = 1'b0;
        end
      end
      S_ARM: begin
        per_d   = per_eff;
        num_d   = i_count;
        width_d = i_width;
        level_d = i_level;
        if (i_stop) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_PULSE;
          cnt_d   = '0;
          idx_d   = idx_q + NUM_W'(1);
        end
      end
      S_PULSE: begin
        cnt_d = cnt_inc;
        if (i_stop) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (cnt_q == EN_LAST) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_inc;
        if (i_stop) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (burst_end && gap_last) begin
          state_d = S_DONE;
        end else if (pulse_ok) begin
          state_d = S_PULSE;
          cnt_d   = '0;
          idx_d   = idx_q + NUM_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      start_hist_q <= 2'b00;
      cnt_q        <= '0;
      per_q        <= '0;
      num_q        <= '0;
      idx_q        <= '0;
      width_q      <= 4'd0;
      level_q      <= 1'b1;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_hist_q <= start_hist_d;
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      num_q        <= num_d;
      idx_q        <= idx_d;
      width_q      <= width_d;
      level_q      <= level_d;
      aborted_q    <= aborted_d;
    end
  end

  // Stop drops the enable in the same cycle, truncating a partial high phase.
  assign o_trig_en    = (state_q == S_PULSE) && !i_stop;
  assign o_trig_width = width_q;
  assign o_trig_level = level_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_aborted    = aborted_q;
  assign o_pulse_idx  = idx_q;

endmodule

// File: tb/tb_trig_burst_sched.sv
// Bench for trig_burst_sched: per-cycle comparison of every output against a
// closed-form burst model (arming cycle, effective period, stop cycle).
module tb_trig_burst_sched;
  localparam int EN_HI = 2;
  localparam int BIG   = 1 << 30;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [15:0] i_period = '0;
  logic [7:0]  i_count = '0;
  logic [3:0]  i_width = '0;
  logic        i_level = 1'b0;
  logic        o_trig_en;
  logic [3:0]  o_trig_width;
  logic        o_trig_level;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;
  logic [7:0]  o_pulse_idx;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int prev_idx = 0;
  int prev_w = 0;
  bit prev_ab = 1'b0;
  bit prev_l = 1'b1;

  trig_burst_sched #(.CNT_W(16), .NUM_W(8), .EN_HI(EN_HI)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_period(i_period), .i_count(i_count), .i_width(i_width), .i_level(i_level),
    .o_trig_en(o_trig_en), .o_trig_width(o_trig_width), .o_trig_level(o_trig_level),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_pulse_idx(o_pulse_idx)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One burst: start in cycle s, edge seen s+1, ARM a=s+2, first pulse f=a+1.
  task automatic run_burst(input int n, input int per, input int wid, input bit lvl,
                           input int stop_off, input bit poke);
    int s, a, f, p, e_nat, x, e, last, exp_idx, exp_w;
    bit stopped, exp_en, exp_ab, exp_l;
    @(posedge i_clk); #1;
    i_count = n[7:0]; i_period = per[15:0]; i_width = wid[3:0]; i_level = lvl; i_start = 1'b1;
    s = cyc; a = s + 2; f = a + 1;
    p = (per > wid + 8) ? per : wid + 8;
    e_nat = (n == 0) ? BIG : f + n * p;
    x = (stop_off >= 0) ? a + stop_off : BIG;
    stopped = (x < e_nat);
    if (!stopped) x = BIG;
    e = stopped ? x + 1 : e_nat;
    for (int c = s; c <= e + 2; c++) begin
      i_stop = (c == x);
      if (c == s + 1) i_start = 1'b0;
      if (poke && c == f + 4) begin
        i_start = 1'b1; i_level = ~i_level; i_width = ~i_width; i_period = 16'd3; i_count = 8'd1;
      end
      if (poke && c == f + 5) i_start = 1'b0;
      @(negedge i_clk);
      exp_en = (c >= f) && (c < e) && (c != x) && (((c - f) % p) < EN_HI);
      if (c < a) exp_idx = prev_idx;
      else if (c == a) exp_idx = 0;
      else begin
        last = (c < e) ? c : e - 1;
        exp_idx = (last >= f) ? ((last - f) / p + 1) % 256 : 0;
      end
      exp_ab = (c < a) ? prev_ab : ((c < e) ? 1'b0 : stopped);
      exp_w  = (c <= a) ? prev_w : wid;
      exp_l  = (c <= a) ? prev_l : lvl;
      check("trig_en", o_trig_en, exp_en);
      check("busy", o_busy, (c >= a && c <= e) ? 1 : 0);
      check("done", o_done, (c == e) ? 1 : 0);
      check("pulse_idx", o_pulse_idx, exp_idx);
      check("aborted", o_aborted, exp_ab);
      check("trig_width", o_trig_width, exp_w);
      check("trig_level", o_trig_level, exp_l);
      @(posedge i_clk); #1;
    end
    i_stop = 1'b0;
    i_start = 1'b0;
    last = e - 1;
    prev_idx = (last >= f) ? ((last - f) / p + 1) % 256 : 0;
    prev_ab = stopped; prev_w = wid; prev_l = lvl;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"}, o_trig_en, 0);
    check({tag, "_width"}, o_trig_width, 0);
    check({tag, "_level"}, o_trig_level, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_aborted"}, o_aborted, 0);
    check({tag, "_idx"}, o_pulse_idx, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, per, wid, p, so;
    bit lvl;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_vals("reset");
    @(posedge i_clk); #1;
    i_rst = 1'b1;

    run_burst(3, 20, 4, 1'b0, -1, 1'b0);
    run_burst(2, 5, 6, 1'b1, -1, 1'b0);
    run_burst(3, 12, 2, 1'b1, -1, 1'b1);

    for (int k = 0; k < 10; k++) begin
      n   = int'($urandom_range(1, 4));
      per = int'($urandom_range(0, 40));
      wid = int'($urandom_range(0, 15));
      lvl = 1'($urandom_range(0, 1));
      p   = (per > wid + 8) ? per : wid + 8;
      so  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n * p)) : -1;
      run_burst(n, per, wid, lvl, so, 1'b0);
    end

    run_burst(0, 16, 5, 1'b1, 16 * 258 + 7, 1'b0);

    // Start and stop together while idle: no burst.
    @(posedge i_clk); #1;
    i_start = 1'b1; i_stop = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      check("ss_busy", o_busy, 0);
      check("ss_done", o_done, 0);
      @(posedge i_clk); #1;
      if (k == 2) i_start = 1'b0;
      if (k == 4) i_stop = 1'b0;
    end

    // Async reset while the enable is high.
    @(posedge i_clk); #1;
    i_count = 8'd2; i_period = 16'd20; i_width = 4'd3; i_level = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("prerst_en", o_trig_en, 1);
    i_rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      check("postrst_done", o_done, 0);
      check("postrst_busy", o_busy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
